// File: rtl/pixel_frame_tx.sv
// Frame transmitter: buffers one N x M frame of pixels and streams it as a single
// contiguous data_valid burst once the downstream filter signals fill_now.
module pixel_frame_tx #(
  parameter int N  = 5,
  parameter int M  = 5,
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_start,
  input  logic          i_loop,
  input  logic          i_fill_now,
  output logic [DW-1:0] o_din,
  output logic          o_data_valid,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_wr_err,
  output logic [15:0]   o_frame_cnt
);

  localparam int              FS        = N * M;
  localparam logic [AW:0]     FS_EXT    = (AW+1)'(FS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(FS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_buf [FS];
  logic [AW-1:0] r_rd_ptr;
  logic          r_last;

  logic          w_addr_ok;
  logic          w_wr_accept;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;

  assign w_addr_ok   = ({1'b0, i_wr_addr} < FS_EXT);
  assign w_wr_accept = i_wr_en && (r_state == IDLE) && w_addr_ok;

  // Single synchronous read port; o_din is the registered read data itself.
  assign w_rd_en   = ((r_state == WAIT_RDY) && i_fill_now) || ((r_state == SEND) && !r_last);
  assign w_rd_addr = (r_state == SEND) ? r_rd_ptr : '0;

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_last       <= 1'b0;
      o_din        <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_wr_err     <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_wr_err     <= i_wr_en && !w_wr_accept;

      if (w_rd_en) begin
        o_din <= r_buf[w_rd_addr];
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= WAIT_RDY;
            o_busy  <= 1'b1;
          end
        end
        WAIT_RDY: begin
          if (i_fill_now) begin
            r_state      <= SEND;
            o_data_valid <= 1'b1;
            r_rd_ptr     <= AW'(1);
            r_last       <= (FS == 1);
          end
        end
        SEND: begin
          // r_last marks that the final pixel is already on o_din.
          if (r_last) begin
            r_state      <= DONE;
            o_data_valid <= 1'b0;
            r_rd_ptr     <= '0;
            r_last       <= 1'b0;
            o_frame_cnt  <= o_frame_cnt + 16'd1;
            o_frame_done <= 1'b1;
          end else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= (r_rd_ptr == LAST_ADDR);
          end
        end
        DONE: begin
          if (i_loop) begin
            r_state <= WAIT_RDY;
          end else begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          o_busy       <= 1'b0;
          o_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Self-checking bench for pixel_frame_tx: table-driven vectors, directed corner
// sequences and randomized writes/noise checked against a frame-buffer model.
module tb_pixel_frame_tx;
  localparam int N  = 5;
  localparam int M  = 5;
  localparam int FS = N * M;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_start = 1'b0;
  logic          i_loop = 1'b0;
  logic          i_fill_now = 1'b0;
  logic [DW-1:0] o_din;
  logic          o_data_valid;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_wr_err;
  logic [15:0]   o_frame_cnt;

  pixel_frame_tx #(.N(N), .M(M), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_loop(i_loop), .i_fill_now(i_fill_now),
    .o_din(o_din), .o_data_valid(o_data_valid), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_wr_err(o_wr_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] ref_mem [FS];
  logic [15:0]   exp_cnt = '0;
  logic          last_we = 1'b0;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          st;
    logic          fn;
    logic          e_busy;
    logic          e_err;
    logic          e_valid;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single write while idle; the model stores only in-range addresses.
  task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    step();
    i_wr_en = 1'b0;
    chk("idle_wr_err", o_wr_err, 32'(int'(a) >= FS));
    if (int'(a) < FS) ref_mem[a] = d;
    $display("write addr=%0d data=%0h err=%0b", a, d, o_wr_err);
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_valid", o_data_valid, 0);
  endtask

  // Called with pixel `first` on o_din; injects random start/fill_now/writes
  // that must all be ignored, and returns with the DUT in the DONE cycle.
  task automatic check_burst(input int first);
    for (int p = first; p < FS; p++) begin
      chk("burst_valid", o_data_valid, 1);
      chk("burst_din", o_din, ref_mem[p]);
      if (p > first) chk("busy_wr_err", o_wr_err, last_we);
      i_start    = 1'($urandom);
      i_fill_now = 1'($urandom);
      i_wr_en    = 1'($urandom);
      i_wr_addr  = AW'($urandom);
      i_wr_data  = DW'($urandom);
      last_we    = i_wr_en;
      step();
    end
    i_wr_en = 1'b0;
    i_start = 1'b0;
    exp_cnt++;
    chk("done_valid", o_data_valid, 0);
    chk("frame_done", o_frame_done, 1);
    chk("frame_cnt", o_frame_cnt, exp_cnt);
    chk("done_wr_err", o_wr_err, last_we);
    $display("frame sent cnt=%0d", o_frame_cnt);
  endtask

  task automatic back_to_idle();
    step();
    chk("idle_frame_done", o_frame_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_data_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic m_busy;
    int   n_wr;
    int   dly;

    // Reset state
    #12;
    chk("rst_din", o_din, 0);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_wr_err", o_wr_err, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    rst_n = 1'b1;
    step();

    // Frame of 1..25, fill_now already high: pixel 0 two edges after start
    for (int p = 0; p < FS; p++) write_px(AW'(p), DW'(p + 1));
    i_fill_now = 1'b1;
    start_frame();
    step();
    check_burst(0);
    back_to_idle();

    // Table vectors: idle writes, out-of-range errors, write+start, busy rejects
    tbl[0] = '{1'b1, 5'd3,  8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd25, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 5'd31, 8'h98, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'd0,  8'hA0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd5,  8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    i_fill_now = 1'b0;
    m_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_wr_en = tbl[i].we; i_wr_addr = tbl[i].a; i_wr_data = tbl[i].d;
      i_start = tbl[i].st; i_fill_now = tbl[i].fn;
      if (tbl[i].we && !m_busy && int'(tbl[i].a) < FS) ref_mem[tbl[i].a] = tbl[i].d;
      if (tbl[i].st) m_busy = 1'b1;
      step();
      chk("tbl_busy", o_busy, tbl[i].e_busy);
      chk("tbl_wr_err", o_wr_err, tbl[i].e_err);
      chk("tbl_valid", o_data_valid, tbl[i].e_valid);
      $display("vector %0d busy=%0b err=%0b valid=%0b", i, o_busy, o_wr_err, o_data_valid);
    end
    i_wr_en = 1'b0; i_start = 1'b0;
    check_burst(0);
    back_to_idle();

    // fill_now low at start, raised 10 cycles later
    i_fill_now = 1'b0;
    start_frame();
    for (int i = 0; i < 10; i++) begin
      chk("wait_valid_low", o_data_valid, 0);
      step();
    end
    chk("wait_still_busy", o_busy, 1);
    i_fill_now = 1'b1;
    step();
    check_burst(0);
    back_to_idle();

    // Looping: three bursts, two idle cycles between them
    i_loop = 1'b1;
    i_fill_now = 1'b1;
    start_frame();
    step();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) i_loop = 1'b0;
      check_burst(0);
      i_fill_now = 1'b1;
      step();
      if (f < 2) begin
        chk("loop_gap_valid", o_data_valid, 0);
        chk("loop_gap_busy", o_busy, 1);
        step();
      end else begin
        chk("loop_end_busy", o_busy, 0);
        chk("loop_end_valid", o_data_valid, 0);
      end
    end
    chk("loop_frame_cnt", o_frame_cnt, exp_cnt);

    // Asynchronous reset at pixel 12
    i_fill_now = 1'b1;
    start_frame();
    step();
    for (int p = 0; p < 12; p++) begin
      chk("pre_rst_din", o_din, ref_mem[p]);
      step();
    end
    chk("pre_rst_valid", o_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_data_valid, 0);
    chk("async_rst_cnt", o_frame_cnt, 0);
    chk("async_rst_busy", o_busy, 0);
    exp_cnt = '0;
    #2;
    rst_n = 1'b1;
    start_frame();
    step();
    check_burst(0);
    back_to_idle();

    // Randomized idle writes and ready delays
    for (int it = 0; it < 6; it++) begin
      n_wr = int'($urandom_range(1, 8));
      for (int w = 0; w < n_wr; w++) write_px(AW'($urandom_range(0, 31)), DW'($urandom));
      i_fill_now = 1'b0;
      start_frame();
      dly = int'($urandom_range(0, 5));
      for (int d = 0; d < dly; d++) begin
        chk("rand_wait_valid", o_data_valid, 0);
        step();
      end
      i_fill_now = 1'b1;
      step();
      check_burst(0);
      i_fill_now = 1'b0;
      back_to_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
